// File: rtl/hello_world_nios2_qsys_oci_dct_packer_if.sv
// Handshake bundle between the OCI trace source, the DCT packer and the trace sink.
// slave  : the packer side (takes atoms, presents frames).
// master : the environment side (offers atoms, sinks frames).
interface hello_world_nios2_qsys_oci_dct_packer_if;
   logic        atom_valid;
   logic [5:0]  atom_data;
   logic        atom_ready;
   logic        flush_req;
   logic        frame_valid;
   logic        frame_ready;
   logic [29:0] frame_data;
   logic [3:0]  frame_count;
   logic [29:0] dct_buffer;
   logic [3:0]  dct_count;
   logic        flush_done;

   modport slave (
      input  atom_valid, atom_data, flush_req, frame_ready,
      output atom_ready, frame_valid, frame_data, frame_count,
             dct_buffer, dct_count, flush_done
   );

   modport master (
      output atom_valid, atom_data, flush_req, frame_ready,
      input  atom_ready, frame_valid, frame_data, frame_count,
             dct_buffer, dct_count, flush_done
   );
endinterface

// File: rtl/hello_world_nios2_qsys_oci_dct_packer.sv
// OCI debug-trace (DCT) packer: packs up to ATOMS trace atoms (first atom in
// the LSBs) into a 30-bit buffer and hands each full or flushed buffer to the
// trace sink as a frame over valid/ready. flush_req drains any partial buffer
// and answers with a one-cycle flush_done pulse.
// Optional feature: define OCI_DCT_IDLE_FLUSH_EN to add an idle timer that
// emits a partial frame after TIMEOUT idle cycles (without flush_done).
module hello_world_nios2_qsys_oci_dct_packer #(
   parameter int ATOM_W  = 6,
   parameter int ATOMS   = 5,
   parameter int TIMEOUT = 15
) (
   input  logic clk,
   input  logic reset,
   hello_world_nios2_qsys_oci_dct_packer_if.slave bus
);

   typedef enum logic {FILL, EMIT} state_t;

   state_t      state;
   logic        flush_pending;
   logic        accept;
   logic [29:0] buf_next;
   logic [3:0]  cnt_next;
   logic        idle_hit;
   logic        emit_now;
   logic        flush_fire;

   // atom_ready is the only decoded output: the packer takes atoms only while filling
   assign bus.atom_ready = (state == FILL);

`ifdef OCI_DCT_IDLE_FLUSH_EN
   logic [3:0] idle_timer;

   // count FILL cycles that hold atoms but see no new atom; any accept or emit restarts it
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         idle_timer <= '0;
      else if (state != FILL || accept || bus.dct_count == 4'd0 || emit_now)
         idle_timer <= '0;
      else if (idle_timer != 4'hF)
         idle_timer <= idle_timer + 4'd1;
   end

   assign idle_hit = (idle_timer == 4'(TIMEOUT));
`else
   // no idle timer: constant 0 for any legal TIMEOUT, partial frames leave only via flush
   assign idle_hit = (TIMEOUT == 0);
`endif

   // next buffer/count including an atom accepted this cycle, plus emit/flush decisions
   always_comb begin
      accept   = (state == FILL) && bus.atom_valid;
      buf_next = bus.dct_buffer;
      cnt_next = bus.dct_count;
      if (accept) begin
         for (int k = 0; k < ATOMS; k++)
            if (k == int'(bus.dct_count))
               buf_next[ATOM_W*k +: ATOM_W] = bus.atom_data;
         cnt_next = bus.dct_count + 4'd1;
      end
      // a flush with nothing buffered (and nothing arriving) completes without a frame
      flush_fire = (state == FILL) && flush_pending && (cnt_next == 4'd0);
      emit_now   = (state == FILL) &&
                   ((cnt_next == 4'(ATOMS)) ||
                    ((flush_pending || idle_hit) && (cnt_next != 4'd0)));
   end

   // packer state machine with registered frame/buffer outputs and flush bookkeeping
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state           <= FILL;
         flush_pending   <= 1'b0;
         bus.flush_done  <= 1'b0;
         bus.frame_valid <= 1'b0;
         bus.frame_data  <= '0;
         bus.frame_count <= '0;
         bus.dct_buffer  <= '0;
         bus.dct_count   <= '0;
      end else begin
         // a request arriving in the completion cycle re-arms the flush
         if (flush_fire)
            flush_pending <= 1'b0;
         if (bus.flush_req)
            flush_pending <= 1'b1;
         bus.flush_done <= flush_fire;

         case (state)
            FILL: begin
               if (emit_now) begin
                  bus.frame_data  <= buf_next;
                  bus.frame_count <= cnt_next;
                  bus.dct_buffer  <= '0;
                  bus.dct_count   <= '0;
                  bus.frame_valid <= 1'b1;
                  state           <= EMIT;
               end else begin
                  bus.dct_buffer <= buf_next;
                  bus.dct_count  <= cnt_next;
               end
            end
            EMIT: begin
               if (bus.frame_ready) begin
                  bus.frame_valid <= 1'b0;
                  state           <= FILL;
               end
            end
            default: state <= FILL;
         endcase
      end
   end

endmodule

// File: tb/tb_hello_world_nios2_qsys_oci_dct_packer.sv
// Self-checking bench for the OCI DCT packer: directed scenarios plus a
// randomized run scored against an atom-queue reference model.
module tb_hello_world_nios2_qsys_oci_dct_packer;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   hello_world_nios2_qsys_oci_dct_packer_if bus();

   hello_world_nios2_qsys_oci_dct_packer dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // reference packing: atom i of a frame lands in bits [6i+5:6i]
   function automatic logic [29:0] pack(input logic [5:0] q[$], input int n);
      logic [29:0] r;
      r = '0;
      for (int i = 0; i < n; i++)
         r = r | (30'(q[i]) << (6 * i));
      return r;
   endfunction

   task automatic idle_inputs();
      bus.atom_valid  = 1'b0;
      bus.atom_data   = '0;
      bus.flush_req   = 1'b0;
      bus.frame_ready = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle_inputs();
      #1;
      checks++;
      if ({bus.atom_ready, bus.frame_valid, bus.flush_done} !== 3'b100) begin
         failures++;
         $display("FAIL reset_ctl got=%b exp=100", {bus.atom_ready, bus.frame_valid, bus.flush_done});
      end
      checks++;
      if ({bus.dct_buffer, bus.dct_count, bus.frame_data, bus.frame_count} !== '0) begin
         failures++;
         $display("FAIL reset_data buf=%h cnt=%0d fd=%h fc=%0d exp all 0",
                  bus.dct_buffer, bus.dct_count, bus.frame_data, bus.frame_count);
      end
      tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic test_full_frame();
      logic [5:0] q[$];
      q = '{6'h01, 6'h02, 6'h03, 6'h04, 6'h05};
      for (int i = 0; i < 5; i++) begin
         bus.atom_valid = 1'b1;
         bus.atom_data  = q[i];
         tick();
         if (i < 4) begin
            checks++;
            if (bus.dct_count !== 4'(i + 1) || bus.dct_buffer !== pack(q, i + 1)) begin
               failures++;
               $display("FAIL full_live i=%0d cnt=%0d buf=%h exp cnt=%0d buf=%h",
                        i, bus.dct_count, bus.dct_buffer, i + 1, pack(q, i + 1));
            end
         end
      end
      bus.atom_valid = 1'b0;
      checks++;
      if (bus.frame_valid !== 1'b1 || bus.atom_ready !== 1'b0) begin
         failures++;
         $display("FAIL full_emit fv=%b ar=%b exp fv=1 ar=0", bus.frame_valid, bus.atom_ready);
      end
      checks++;
      if (bus.frame_data !== pack(q, 5) || bus.frame_count !== 4'd5 || bus.dct_count !== 4'd0) begin
         failures++;
         $display("FAIL full_frame fd=%h fc=%0d cnt=%0d exp fd=%h fc=5 cnt=0",
                  bus.frame_data, bus.frame_count, bus.dct_count, pack(q, 5));
      end
      tick();
      checks++;
      if (bus.frame_valid !== 1'b0 || bus.atom_ready !== 1'b1) begin
         failures++;
         $display("FAIL full_after fv=%b ar=%b exp fv=0 ar=1", bus.frame_valid, bus.atom_ready);
      end
   endtask

   task automatic test_backpressure();
      logic [5:0]  q[$];
      logic [29:0] exp;
      int          bad;
      bus.frame_ready = 1'b0;
      for (int i = 0; i < 5; i++) q.push_back(6'($urandom));
      exp = pack(q, 5);
      for (int i = 0; i < 5; i++) begin
         bus.atom_valid = 1'b1;
         bus.atom_data  = q[i];
         tick();
      end
      // keep offering atoms: none may be taken while the frame is stalled
      bad = 0;
      for (int c = 0; c < 10; c++) begin
         bus.atom_data = 6'($urandom);
         tick();
         if (bus.frame_valid !== 1'b1 || bus.atom_ready !== 1'b0 ||
             bus.frame_data !== exp || bus.frame_count !== 4'd5 || bus.dct_count !== 4'd0)
            bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL backpressure_hold bad_cycles=%0d exp=0 fd=%h exp_fd=%h", bad, bus.frame_data, exp);
      end
      bus.atom_valid  = 1'b0;
      bus.frame_ready = 1'b1;
      tick();
      checks++;
      if (bus.atom_ready !== 1'b1 || bus.frame_valid !== 1'b0) begin
         failures++;
         $display("FAIL backpressure_release ar=%b fv=%b exp ar=1 fv=0", bus.atom_ready, bus.frame_valid);
      end
   endtask

   task automatic test_partial_flush();
      logic [5:0] q[$];
      q = '{6'h3F, 6'h2A};
      for (int i = 0; i < 2; i++) begin
         bus.atom_valid = 1'b1;
         bus.atom_data  = q[i];
         tick();
      end
      bus.atom_valid = 1'b0;
      bus.flush_req  = 1'b1;
      tick();
      bus.flush_req = 1'b0;
      tick();
      checks++;
      if (bus.frame_valid !== 1'b1 || bus.frame_data !== pack(q, 2) || bus.frame_count !== 4'd2) begin
         failures++;
         $display("FAIL partial_frame fv=%b fd=%h fc=%0d exp fv=1 fd=%h fc=2",
                  bus.frame_valid, bus.frame_data, bus.frame_count, pack(q, 2));
      end
      tick();   // handshake edge
      checks++;
      if (bus.frame_valid !== 1'b0 || bus.flush_done !== 1'b0) begin
         failures++;
         $display("FAIL partial_hs fv=%b fdone=%b exp 0 0", bus.frame_valid, bus.flush_done);
      end
      tick();
      checks++;
      if (bus.flush_done !== 1'b1) begin
         failures++;
         $display("FAIL partial_done fdone=%b exp=1", bus.flush_done);
      end
      tick();
      checks++;
      if (bus.flush_done !== 1'b0) begin
         failures++;
         $display("FAIL partial_done_pulse fdone=%b exp=0", bus.flush_done);
      end
   endtask

   task automatic test_empty_flush();
      int fv_seen;
      fv_seen = 0;
      bus.flush_req = 1'b1;
      tick();
      bus.flush_req = 1'b0;
      fv_seen |= bus.frame_valid;
      checks++;
      if (bus.flush_done !== 1'b0) begin
         failures++;
         $display("FAIL empty_early fdone=%b exp=0", bus.flush_done);
      end
      tick();
      fv_seen |= bus.frame_valid;
      checks++;
      if (bus.flush_done !== 1'b1) begin
         failures++;
         $display("FAIL empty_done fdone=%b exp=1", bus.flush_done);
      end
      tick();
      fv_seen |= bus.frame_valid;
      checks++;
      if (fv_seen != 0 || bus.flush_done !== 1'b0) begin
         failures++;
         $display("FAIL empty_noframe fv_seen=%0d fdone=%b exp 0 0", fv_seen, bus.flush_done);
      end
   endtask

   task automatic test_simultaneous();
      logic [5:0] a;
      a = 6'($urandom);
      bus.atom_valid = 1'b1;
      bus.atom_data  = a;
      bus.flush_req  = 1'b1;
      tick();
      bus.atom_valid = 1'b0;
      bus.flush_req  = 1'b0;
      tick();
      checks++;
      if (bus.frame_valid !== 1'b1 || bus.frame_count !== 4'd1 || bus.frame_data !== 30'(a)) begin
         failures++;
         $display("FAIL simul_frame fv=%b fc=%0d fd=%h exp fv=1 fc=1 fd=%h",
                  bus.frame_valid, bus.frame_count, bus.frame_data, 30'(a));
      end
      tick();
      tick();
      checks++;
      if (bus.flush_done !== 1'b1) begin
         failures++;
         $display("FAIL simul_done fdone=%b exp=1", bus.flush_done);
      end
      tick();
   endtask

   task automatic test_idle();
      int seen;
      int fd;
      seen = -1;
      fd   = 0;
      bus.atom_valid = 1'b1;
      bus.atom_data  = 6'h11;
      tick();
      bus.atom_valid = 1'b0;
      for (int t = 1; t <= 40 && seen < 0; t++) begin
         tick();
         fd |= bus.flush_done;
         if (bus.frame_valid) seen = t;
      end
`ifdef OCI_DCT_IDLE_FLUSH_EN
      checks++;
      if (seen < 15 || seen > 16 || bus.frame_count !== 4'd1 || bus.frame_data !== 30'h11) begin
         failures++;
         $display("FAIL idle_frame at=%0d fc=%0d fd=%h exp at=15..16 fc=1 fd=00000011",
                  seen, bus.frame_count, bus.frame_data);
      end
      for (int t = 0; t < 4; t++) begin
         tick();
         fd |= bus.flush_done;
      end
      checks++;
      if (fd != 0) begin
         failures++;
         $display("FAIL idle_no_done flush_done_seen=%0d exp=0", fd);
      end
`else
      checks++;
      if (seen != -1) begin
         failures++;
         $display("FAIL idle_noframe frame at cycle %0d exp none", seen);
      end
      bus.flush_req = 1'b1;
      tick();
      bus.flush_req = 1'b0;
      tick();
      checks++;
      if (bus.frame_valid !== 1'b1 || bus.frame_count !== 4'd1 || bus.frame_data !== 30'h11) begin
         failures++;
         $display("FAIL idle_drain fv=%b fc=%0d fd=%h exp fv=1 fc=1 fd=00000011",
                  bus.frame_valid, bus.frame_count, bus.frame_data);
      end
      tick();
      tick();
      tick();
`endif
   endtask

   task automatic test_reset_mid_emit();
      int fv_seen;
      bus.frame_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         bus.atom_valid = 1'b1;
         bus.atom_data  = 6'($urandom);
         tick();
      end
      bus.atom_valid = 1'b0;
      checks++;
      if (bus.frame_valid !== 1'b1) begin
         failures++;
         $display("FAIL rst_pre fv=%b exp=1", bus.frame_valid);
      end
      reset = 1'b1;
      #1;
      checks++;
      if (bus.frame_valid !== 1'b0 || bus.dct_count !== 4'd0 || bus.dct_buffer !== 30'd0 ||
          bus.frame_data !== 30'd0 || bus.frame_count !== 4'd0 || bus.atom_ready !== 1'b1) begin
         failures++;
         $display("FAIL rst_mid fv=%b cnt=%0d buf=%h fd=%h fc=%0d ar=%b exp 0 0 0 0 0 1",
                  bus.frame_valid, bus.dct_count, bus.dct_buffer, bus.frame_data,
                  bus.frame_count, bus.atom_ready);
      end
      tick();
      reset = 1'b0;
      bus.frame_ready = 1'b1;
      fv_seen = 0;
      for (int t = 0; t < 3; t++) begin
         tick();
         fv_seen |= bus.frame_valid;
      end
      checks++;
      if (fv_seen != 0) begin
         failures++;
         $display("FAIL rst_noframe fv_seen=%0d exp=0", fv_seen);
      end
   endtask

   task automatic test_random();
      logic [5:0] q[$];
      int         gap;
      int         n;
      int         done;
      gap = 0;
      for (int c = 0; c < 400; c++) begin
         // keep idle gaps short so an idle timer never fires mid-run
         bus.atom_valid  = ($urandom_range(0, 3) != 0) || (gap >= 8);
         bus.atom_data   = 6'($urandom);
         bus.frame_ready = ($urandom_range(0, 3) != 0);
         gap = bus.atom_valid ? 0 : gap + 1;
         checks++;
         if (bus.atom_ready !== ~bus.frame_valid) begin
            failures++;
            $display("FAIL rand_ready c=%0d ar=%b fv=%b", c, bus.atom_ready, bus.frame_valid);
         end
         if (bus.atom_valid && bus.atom_ready) q.push_back(bus.atom_data);
         if (bus.frame_valid && bus.frame_ready) begin
            checks++;
            if (q.size() < 5 || bus.frame_count !== 4'd5 || bus.frame_data !== pack(q, 5)) begin
               failures++;
               $display("FAIL rand_frame c=%0d fd=%h fc=%0d exp fd=%h fc=5 queued=%0d",
                        c, bus.frame_data, bus.frame_count, pack(q, 5), q.size());
            end
            for (int i = 0; i < 5 && q.size() > 0; i++) void'(q.pop_front());
         end
         tick();
      end
      // drain whatever is buffered through a flush
      bus.atom_valid  = 1'b0;
      bus.frame_ready = 1'b1;
      bus.flush_req   = 1'b1;
      done = 0;
      for (int t = 0; t < 30 && done == 0; t++) begin
         if (bus.frame_valid && bus.frame_ready) begin
            n = (q.size() < 5) ? q.size() : 5;
            checks++;
            if (n == 0 || bus.frame_count !== 4'(n) || bus.frame_data !== pack(q, n)) begin
               failures++;
               $display("FAIL rand_drain fd=%h fc=%0d exp fd=%h fc=%0d",
                        bus.frame_data, bus.frame_count, pack(q, n), n);
            end
            for (int i = 0; i < n; i++) void'(q.pop_front());
         end
         tick();
         bus.flush_req = 1'b0;
         if (bus.flush_done) done = 1;
      end
      checks++;
      if (done == 0 || q.size() != 0) begin
         failures++;
         $display("FAIL rand_flush done=%0d leftover=%0d exp done=1 leftover=0", done, q.size());
      end
   endtask

   initial begin
      test_reset();
      test_full_frame();
      test_backpressure();
      test_partial_flush();
      test_empty_flush();
      test_simultaneous();
      test_idle();
      test_reset_mid_emit();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
